// File: rtl/aes_job_arbiter.sv
// Two-requester round-robin arbiter in front of a shared AES core.
// Latches the winner's plaintext/key, starts the core, and returns the ciphertext or a timeout error.
module aes_job_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 200
) (
  input  logic         int_osc,
  input  logic         reset,
  input  logic         req0,
  input  logic [127:0] pt0,
  input  logic [127:0] key0,
  input  logic         req1,
  input  logic [127:0] pt1,
  input  logic [127:0] key1,
  output logic         ack0,
  output logic         ack1,
  output logic         core_start,
  output logic [127:0] core_pt,
  output logic [127:0] core_key,
  input  logic         core_done,
  input  logic [127:0] core_ct,
  output logic         rsp_valid0,
  output logic         rsp_valid1,
  output logic [127:0] rsp_data,
  output logic         rsp_err,
  output logic         busy
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GRANT = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    RESP  = 3'd4
  } state_t;

  state_t           state;
  logic             owner;
  logic             last_owner;
  logic [CNT_W-1:0] wait_cnt;
  logic             win_c;

  // Round-robin pick: a lone requester wins, a tie goes to whoever did not win last.
  always_comb begin
    win_c = 1'b0;
    if (req0 && req1) begin
      win_c = ~last_owner;
    end else begin
      win_c = req1;
    end
  end

  // Job sequencer; pulse outputs default low and are raised for exactly one state.
  always_ff @(posedge int_osc or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      wait_cnt   <= '0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      core_start <= 1'b0;
      core_pt    <= '0;
      core_key   <= '0;
      rsp_valid0 <= 1'b0;
      rsp_valid1 <= 1'b0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      core_start <= 1'b0;
      rsp_valid0 <= 1'b0;
      rsp_valid1 <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            owner      <= win_c;
            last_owner <= win_c;
            core_pt    <= win_c ? pt1 : pt0;
            core_key   <= win_c ? key1 : key0;
            ack0       <= ~win_c;
            ack1       <= win_c;
            busy       <= 1'b1;
            state      <= GRANT;
          end
        end
        GRANT: begin
          core_start <= 1'b1;
          state      <= START;
        end
        START: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          // A completion in the final timeout cycle still counts as success.
          if (core_done) begin
            rsp_data   <= core_ct;
            rsp_err    <= 1'b0;
            rsp_valid0 <= ~owner;
            rsp_valid1 <= owner;
            state      <= RESP;
          end else if (wait_cnt == CNT_LAST) begin
            rsp_data   <= '0;
            rsp_err    <= 1'b1;
            rsp_valid0 <= ~owner;
            rsp_valid1 <= owner;
            state      <= RESP;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        RESP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_job_arbiter.sv
// Self-checking bench for aes_job_arbiter: vector table of jobs with a response scoreboard,
// plus hand-written sequences for reset abandonment and stray core completions.
module tb_aes_job_arbiter;

  localparam int TMO = 20;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  typedef struct {
    logic         r0;
    logic         r1;
    logic [127:0] pt;
    logic [127:0] key;
    logic [127:0] ct;
    int           delay;
    logic         owner;
    logic         err;
  } vec_t;

  typedef struct {
    logic         owner;
    logic         err;
    logic [127:0] data;
  } exp_t;

  logic         int_osc = 1'b0;
  logic         reset;
  logic         req0, req1;
  logic [127:0] pt0, key0, pt1, key1;
  logic         ack0, ack1, core_start;
  logic [127:0] core_pt, core_key;
  logic         core_done;
  logic [127:0] core_ct;
  logic         rsp_valid0, rsp_valid1;
  logic [127:0] rsp_data;
  logic         rsp_err;
  logic         busy;

  int vectors = 0;
  int errors  = 0;
  int cyc = 0;
  int n_ack = 0, n_rsp = 0, n_start = 0;
  int ack_cyc = 0, rsp_cyc = 0;
  logic ack_owner = 1'b0;
  int cd = 0, cur_delay = 0;
  logic [127:0] cur_ct = '0;
  exp_t sb[$];
  vec_t vecs[10];

  aes_job_arbiter #(.TIMEOUT_CYC(TMO)) dut (
    .int_osc(int_osc), .reset(reset),
    .req0(req0), .pt0(pt0), .key0(key0),
    .req1(req1), .pt1(pt1), .key1(key1),
    .ack0(ack0), .ack1(ack1),
    .core_start(core_start), .core_pt(core_pt), .core_key(core_key),
    .core_done(core_done), .core_ct(core_ct),
    .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 int_osc = ~int_osc;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r0, input logic r1, input int d,
                              input logic own, input logic err, input int seed);
    vec_t v;
    v.r0    = r0;
    v.r1    = r1;
    v.pt    = FIPS_PT ^ {4{32'(seed) * 32'h01030507}};
    v.key   = FIPS_KEY ^ {4{32'(seed) * 32'h11000011}};
    v.ct    = FIPS_CT ^ {4{32'(seed) * 32'h00a000b1}};
    v.delay = d;
    v.owner = own;
    v.err   = err;
    return v;
  endfunction

  // One clock: sample just after the edge, model the core, and score responses.
  task automatic step();
    exp_t e;
    @(posedge int_osc);
    #1;
    cyc++;
    core_done = 1'b0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) core_done = 1'b1;
    end
    core_ct = core_done ? cur_ct : {4{$urandom}};
    if (core_start) begin
      n_start++;
      if (cur_delay > 0) cd = cur_delay;
    end
    if (ack0 || ack1) begin
      n_ack++;
      ack_cyc   = cyc;
      ack_owner = ack1;
      chk("ack_onehot", 128'(ack0 & ack1), 128'(0));
    end
    if (rsp_valid0 || rsp_valid1) begin
      n_rsp++;
      rsp_cyc = cyc;
      chk("rsp_onehot", 128'(rsp_valid0 & rsp_valid1), 128'(0));
      if (sb.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL rsp_unexpected: got rsp_valid0=%0b rsp_valid1=%0b expected no response",
                 rsp_valid0, rsp_valid1);
      end else begin
        e = sb.pop_front();
        chk("rsp_owner", 128'(rsp_valid1), 128'(e.owner));
        chk("rsp_err", 128'(rsp_err), 128'(e.err));
        chk("rsp_data", rsp_data, e.data);
      end
    end
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_ctl"}, 128'({busy, ack0, ack1, core_start, rsp_valid0, rsp_valid1, rsp_err}), 128'(0));
    chk({tag, "_core_pt"}, core_pt, '0);
    chk({tag, "_core_key"}, core_key, '0);
    chk({tag, "_rsp_data"}, rsp_data, '0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    core_done = 1'b0;
    cur_delay = 0;
    cd = 0;
    step();
    step();
    check_idle_zero("reset");
    reset = 1'b0;
    sb.delete();
  endtask

  task automatic run_job(input vec_t v);
    int a0, r0, s0, drv, lat;
    logic idle;
    logic [127:0] ept, ekey;
    exp_t e;
    req0 = v.r0; req1 = v.r1;
    pt0 = v.pt; key0 = v.key; pt1 = ~v.pt; key1 = ~v.key;
    cur_delay = v.delay;
    cur_ct = v.ct;
    idle = !busy;
    drv = cyc;
    a0 = n_ack; r0 = n_rsp; s0 = n_start;
    ept  = v.owner ? ~v.pt : v.pt;
    ekey = v.owner ? ~v.key : v.key;
    e.owner = v.owner;
    e.err   = v.err;
    e.data  = v.err ? '0 : v.ct;
    sb.push_back(e);
    for (int i = 0; i < 8 && n_ack == a0; i++) step();
    chk("ack_seen", 128'(n_ack - a0), 128'(1));
    if (n_ack == a0) begin
      sb.delete();
      return;
    end
    chk("ack_owner", 128'(ack_owner), 128'(v.owner));
    if (idle) chk("ack_latency", 128'(ack_cyc), 128'(drv + 1));
    if (v.owner) req1 = 1'b0; else req0 = 1'b0;
    step();
    chk("start_pulse", 128'(core_start), 128'(1));
    chk("core_pt", core_pt, ept);
    chk("core_key", core_key, ekey);
    // Requester inputs wander while the core runs; the latched job must not move.
    pt0 = {4{$urandom}}; key0 = {4{$urandom}};
    pt1 = {4{$urandom}}; key1 = {4{$urandom}};
    for (int i = 0; i < TMO + 12 && n_rsp == r0; i++) step();
    chk("rsp_seen", 128'(n_rsp - r0), 128'(1));
    lat = (v.delay == 0 || v.delay > TMO) ? TMO : v.delay;
    chk("rsp_latency", 128'(rsp_cyc), 128'(ack_cyc + 2 + lat));
    chk("core_pt_hold", core_pt, ept);
    chk("core_key_hold", core_key, ekey);
    chk("start_count", 128'(n_start - s0), 128'(1));
    chk("ack_count", 128'(n_ack - a0), 128'(1));
  endtask

  initial begin
    int a0, r0;
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    pt0 = '0; key0 = '0; pt1 = '0; key1 = '0;
    core_done = 1'b0;
    core_ct = '0;

    //        r0    r1   delay owner err  seed
    vecs[0] = mk(1'b1, 1'b1, 3,  1'b0, 1'b0, 1);  // tie after reset -> 0
    vecs[1] = mk(1'b1, 1'b1, 1,  1'b1, 1'b0, 2);  // tie -> 1, minimum latency
    vecs[2] = mk(1'b1, 1'b1, 5,  1'b0, 1'b0, 3);  // third tie -> 0
    vecs[3] = mk(1'b0, 1'b1, 20, 1'b1, 1'b0, 4);  // done in last timeout cycle
    vecs[4] = mk(1'b0, 1'b1, 0,  1'b1, 1'b1, 5);  // no done -> timeout
    vecs[5] = mk(1'b1, 1'b0, 22, 1'b0, 1'b1, 6);  // late done lands in IDLE
    vecs[6] = mk(1'b1, 1'b1, 19, 1'b1, 1'b0, 7);
    vecs[7] = mk(1'b1, 1'b0, 2,  1'b0, 1'b0, 8);
    vecs[8] = mk(1'b0, 1'b1, 21, 1'b1, 1'b1, 9);  // done lands in RESP
    vecs[9] = mk(1'b1, 1'b1, 7,  1'b0, 1'b0, 10);

    // Known-answer single job straight out of reset.
    do_reset();
    run_job('{1'b1, 1'b0, FIPS_PT, FIPS_KEY, FIPS_CT, 10, 1'b0, 1'b0});
    req0 = 1'b0; req1 = 1'b0;

    do_reset();
    for (int i = 0; i < 10; i++) run_job(vecs[i]);
    req0 = 1'b0; req1 = 1'b0;

    // Stray completion while idle.
    repeat (3) step();
    r0 = n_rsp;
    core_done = 1'b1;
    core_ct = {4{$urandom}};
    repeat (6) step();
    chk("stray_done_rsp", 128'(n_rsp - r0), 128'(0));
    chk("stray_done_busy", 128'(busy), 128'(0));
    chk("stray_done_data", rsp_data, vecs[9].ct);
    chk("stray_done_err", 128'(rsp_err), 128'(0));

    // Reset three cycles into WAIT abandons the job.
    req0 = 1'b1;
    pt0 = FIPS_PT; key0 = FIPS_KEY;
    cur_delay = 0;
    a0 = n_ack;
    for (int i = 0; i < 8 && n_ack == a0; i++) step();
    chk("abort_ack_seen", 128'(n_ack - a0), 128'(1));
    req0 = 1'b0;
    step();
    chk("abort_start", 128'(core_start), 128'(1));
    repeat (3) step();
    reset = 1'b1;
    #1;
    check_idle_zero("async_reset");
    step();
    step();
    reset = 1'b0;
    a0 = n_ack;
    r0 = n_rsp;
    core_done = 1'b1;
    core_ct = FIPS_CT;
    repeat (30) step();
    chk("abort_no_rsp", 128'(n_rsp - r0), 128'(0));
    chk("abort_no_ack", 128'(n_ack - a0), 128'(0));
    check_idle_zero("abort_after");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/aes_job_arbiter.md
AES_JOB_ARBITER -- requirements
Module: aes_job_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYC, 200, max cycles in WAIT before abort (1..65535).
REQ-002 Ports, one per line:
- int_osc  in  1  sole clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0  in  1  requester 0 job request, level, held until ack0.
- pt0  in  128  requester 0 plaintext, valid while req0=1.
- key0  in  128  requester 0 key, valid while req0=1.
- req1  in  1  requester 1 job request.
- pt1  in  128  requester 1 plaintext.
- key1  in  128  requester 1 key.
- ack0  out  1  one-cycle pulse: requester 0 job accepted.
- ack1  out  1  one-cycle pulse: requester 1 job accepted.
- core_start  out  1  one-cycle start pulse to shared AES core.
- core_pt  out  128  plaintext to core.
- core_key  out  128  key to core.
- core_done  in  1  core completion pulse.
- core_ct  in  128  core ciphertext, valid when core_done=1.
- rsp_valid0  out  1  one-cycle pulse: rsp_data belongs to requester 0.
- rsp_valid1  out  1  one-cycle pulse: rsp_data belongs to requester 1.
- rsp_data  out  128  ciphertext, or all-zero on timeout.
- rsp_err  out  1  qualifies rsp_valid0/1: 1 = job timed out.
- busy  out  1  1 in every state except IDLE.
REQ-003 The block SHALL use one clock (int_osc); reset SHALL be asynchronous and active-high.

Function
REQ-004 FSM states SHALL be IDLE, GRANT, START, WAIT, RESP; every output SHALL be a registered output or decoded from state only.
REQ-005 IDLE: if either req is 1, the block SHALL select a winner, latch its pt/key into core_pt/core_key, set owner, and go to GRANT; else stay in IDLE.
REQ-006 Arbitration SHALL be round-robin: one req -> that requester wins; both -> winner is the requester not equal to last_owner.
REQ-007 last_owner SHALL update to the winner on the IDLE->GRANT transition.
REQ-008 GRANT: ack of the owner SHALL be 1 for exactly this cycle; next state START.
REQ-009 START: core_start SHALL be 1 for exactly this cycle; wait counter cleared to 0; next state WAIT.
REQ-010 core_pt/core_key SHALL stay stable from GRANT through RESP, regardless of req/pt/key changes.
REQ-011 WAIT: the 16-bit counter SHALL increment each cycle; core_done=1 -> capture core_ct into rsp_data, rsp_err=0, go RESP.
REQ-012 WAIT: counter == TIMEOUT_CYC-1 with core_done=0 -> rsp_data=0, rsp_err=1, go RESP.
REQ-013 core_done and timeout in the same cycle: done SHALL win (rsp_err=0).
REQ-014 RESP: the owner's rsp_valid SHALL be 1 for exactly this cycle; rsp_data/rsp_err held until the next RESP; next state IDLE.
REQ-015 core_done outside WAIT SHALL be ignored.
REQ-016 Minimum latency IDLE req -> rsp_valid = 4 cycles plus core latency (done in first WAIT cycle -> rsp_valid 4 cycles after IDLE sample).
REQ-017 A req still high in IDLE after its RESP SHALL be treated as a new job.
REQ-018 Never more than one of ack0/ack1, or of rsp_valid0/rsp_valid1, SHALL be 1 in a cycle.

Reset
REQ-019 Reset asserted SHALL force IDLE, last_owner=1 (requester 0 wins first tie), and counter=0.
REQ-020 Reset asserted SHALL force all outputs to 0, including core_pt, core_key, rsp_data and rsp_err.
REQ-021 Reset mid-job SHALL abandon the job: no ack or rsp pulse is issued for it after release.
REQ-022 First grant SHALL be possible on the first rising edge after reset deassertion.

Verification
REQ-023 Single job: req0=1, pt0=0x00112233445566778899aabbccddeeff, key0=0x000102...0f, core_done 10 cycles after core_start with core_ct=0x69c4e0d86a7b0430d8cdb78070b4c55a -> ack0 one pulse, core_start one pulse, rsp_valid0 with that data, rsp_err=0.
REQ-024 Tie after reset: req0=req1=1 -> order ack0, rsp_valid0, ack1, rsp_valid1; third job with both high goes to requester 0.
REQ-025 Timeout: TIMEOUT_CYC=20, core_done never -> rsp_valid of owner exactly 20 cycles after entering WAIT, rsp_err=1, rsp_data=0, then IDLE.
REQ-026 Done/timeout collision: core_done asserted on cycle TIMEOUT_CYC-1 of WAIT -> rsp_err=0, rsp_data=core_ct.
REQ-027 Reset in WAIT: assert reset 3 cycles after core_start, later core_done=1 -> no rsp_valid, busy=0, outputs 0.
REQ-028 Stability: change pt0/key0 during WAIT -> core_pt/core_key unchanged; stray core_done in IDLE -> no rsp_valid.
